// File: rtl/duty_slew_ctrl.sv
// Duty-cycle slew controller: holds a written target and steps the live duty
// toward it by a programmable amount, changing only at PWM period wraps.
module duty_slew_ctrl #(
    parameter logic [7:0] RESET_DUTY = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr,
    input  logic [7:0] wr_data,
    input  logic [7:0] step,
    output logic [7:0] duty,
    output logic       settled,
    output logic       period_tick
);

    typedef enum logic [1:0] {
        ST_SETTLED = 2'b00,
        ST_UP      = 2'b01,
        ST_DOWN    = 2'b10
    } dir_t;

    logic [7:0] cnt_r;
    logic [7:0] target_r;
    logic [7:0] duty_r;
    logic       settled_r;
    logic       period_tick_r;

    dir_t       state_s;
    logic       boundary_s;
    logic [7:0] diff_s;
    logic [7:0] duty_nxt_s;
    logic [7:0] target_nxt_s;

    // Ramp direction is derived purely from the duty/target relation.
    always_comb begin
        if (duty_r == target_r) begin
            state_s = ST_SETTLED;
        end else if (duty_r < target_r) begin
            state_s = ST_UP;
        end else begin
            state_s = ST_DOWN;
        end
    end

    // Next-state logic: the boundary update uses the target held before any
    // same-edge write, and the difference is compared before stepping so the
    // duty never overshoots or wraps.
    always_comb begin
        boundary_s   = (cnt_r == 8'hFF);
        diff_s       = 8'h00;
        duty_nxt_s   = duty_r;
        if (wr) begin
            target_nxt_s = wr_data;
        end else begin
            target_nxt_s = target_r;
        end
        if (boundary_s) begin
            case (state_s)
                ST_UP: begin
                    diff_s = target_r - duty_r;
                    if ((step == 8'h00) || (diff_s <= step)) begin
                        duty_nxt_s = target_r;
                    end else begin
                        duty_nxt_s = duty_r + step;
                    end
                end
                ST_DOWN: begin
                    diff_s = duty_r - target_r;
                    if ((step == 8'h00) || (diff_s <= step)) begin
                        duty_nxt_s = target_r;
                    end else begin
                        duty_nxt_s = duty_r - step;
                    end
                end
                default: begin
                    duty_nxt_s = duty_r;
                end
            endcase
        end else begin
            duty_nxt_s = duty_r;
        end
    end

    // State registers; status flags are computed from next values so they
    // line up with the registered duty and target they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r         <= 8'h00;
            target_r      <= RESET_DUTY;
            duty_r        <= RESET_DUTY;
            settled_r     <= 1'b1;
            period_tick_r <= 1'b1;
        end else begin
            cnt_r         <= cnt_r + 8'd1;
            target_r      <= target_nxt_s;
            duty_r        <= duty_nxt_s;
            settled_r     <= (duty_nxt_s == target_nxt_s);
            period_tick_r <= boundary_s;
        end
    end

    assign duty        = duty_r;
    assign settled     = settled_r;
    assign period_tick = period_tick_r;

endmodule

// File: tb/tb_duty_slew_ctrl.sv
// Scoreboard bench for duty_slew_ctrl: a cycle-level arithmetic model pushes
// expected outputs per edge; a monitor pops and compares after each edge.
module tb_duty_slew_ctrl;

    localparam logic [7:0] RST_D = 8'h00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] step = 8'h00;
    logic [7:0] duty;
    logic       settled;
    logic       period_tick;

    always #5 clk = ~clk;

    duty_slew_ctrl #(.RESET_DUTY(RST_D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr          (wr),
        .wr_data     (wr_data),
        .step        (step),
        .duty        (duty),
        .settled     (settled),
        .period_tick (period_tick)
    );

    typedef struct {
        int duty;
        int settled;
        int tick;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         m_cnt;
    int         m_duty;
    int         m_target;
    logic [7:0] cur_step;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_duty   = RST_D;
        m_target = RST_D;
    endtask

    task automatic push_exp();
        exp_t e;
        e.duty    = m_duty;
        e.settled = (m_duty == m_target) ? 1 : 0;
        e.tick    = (m_cnt == 0) ? 1 : 0;
        sb.push_back(e);
    endtask

    // One clock cycle: drive inputs, then predict the state after the next edge.
    task automatic cyc(input bit w, input int d);
        int diff;
        int s;
        @(negedge clk);
        rst_n   = 1'b1;
        wr      = w;
        wr_data = d[7:0];
        step    = cur_step;
        if (m_cnt == 255) begin
            diff = m_target - m_duty;
            s    = int'(cur_step);
            if (diff > 0)
                m_duty = m_duty + (((s == 0) || (diff <= s)) ? diff : s);
            else if (diff < 0)
                m_duty = m_duty - (((s == 0) || (-diff <= s)) ? -diff : s);
        end
        if (w) m_target = d;
        m_cnt = (m_cnt + 1) % 256;
        push_exp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0);
    endtask

    task automatic wait_cnt(input int k);
        for (int j = 0; j < 256 && m_cnt != k; j++) cyc(1'b0, 0);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        wr    = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("async_duty", int'(duty), int'(RST_D));
        chk("async_settled", int'(settled), 1);
        chk("async_tick", int'(period_tick), 1);
        model_reset();
        push_exp();
        repeat (2) begin
            @(negedge clk);
            push_exp();
        end
    endtask

    // Monitor: one expected entry per rising edge once stimulus is running.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("duty", int'(duty), e.duty);
                chk("settled", int'(settled), e.settled);
                chk("period_tick", int'(period_tick), e.tick);
            end
        end
    end

    initial begin
        cur_step = 8'h00;
        @(negedge clk);
        #1;
        chk("reset_duty", int'(duty), int'(RST_D));
        chk("reset_settled", int'(settled), 1);
        chk("reset_tick", int'(period_tick), 1);
        model_reset();

        // Quiet periods: ticks at 0/256/512 and no duty movement.
        idle(600);

        // Upward ramp from 0 to 0x40 in 0x10 steps.
        model_reset();
        mid_reset();
        cur_step = 8'h10;
        wait_cnt(10);
        cyc(1'b1, 'h40);
        idle(4 * 256 + 20);

        // Downward ramp with clamp, then no-wrap approach to 0xFF.
        cyc(1'b1, 'h05);
        idle(4 * 256 + 10);
        cur_step = 8'h00;
        cyc(1'b1, 'hF8);
        idle(300);
        cur_step = 8'h10;
        cyc(1'b1, 'hFF);
        idle(300);

        // Writes just before and exactly on the boundary edge.
        cur_step = 8'h00;
        wait_cnt(254);
        cyc(1'b1, 'hA0);
        idle(3);
        wait_cnt(255);
        cyc(1'b1, 'h11);
        idle(300);

        // Mid-ramp reversal.
        cyc(1'b1, 'h20);
        idle(300);
        cur_step = 8'h10;
        wait_cnt(5);
        cyc(1'b1, 'h80);
        wait_cnt(0);
        cyc(1'b1, 'h10);
        idle(3 * 256);

        // Reset in the middle of a slow ramp; old target must be gone.
        cur_step = 8'h01;
        cyc(1'b1, 'hF0);
        idle(600);
        wait_cnt(100);
        mid_reset();
        idle(600);

        // Randomized writes and step changes.
        for (int i = 0; i < 30000; i++) begin
            if ($urandom_range(0, 199) == 0)
                cur_step = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 64));
            if ($urandom_range(0, 99) == 0)
                cyc(1'b1, int'($urandom_range(0, 255)));
            else
                cyc(1'b0, 0);
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
        #2;
        chk("scoreboard_drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
